// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end for a 256x16 synchronous instruction memory.
// Streams sequential instructions into a 2-entry buffer or forwards loader writes.
module inst_fetch_unit #(
  parameter logic [7:0] START_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_mode,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [7:0]  load_addr,
  input  logic [15:0] load_data,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [15:0] inst_data,
  output logic [7:0]  inst_pc,
  output logic        mem_rw_enable,
  output logic [7:0]  mem_address,
  output logic [15:0] mem_data_in,
  input  logic [15:0] mem_data_out
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD} state_e;

  state_e      state_q, state_d;
  logic [7:0]  fetch_pc_q, fetch_pc_d;
  logic        inflight_q, inflight_d;
  logic [7:0]  inflight_pc_q, inflight_pc_d;
  logic [1:0]  count_q, count_d;
  logic [7:0]  pc0_q, pc0_d, pc1_q, pc1_d;
  logic [15:0] inst0_q, inst0_d, inst1_q, inst1_d;

  logic       pop, push, issue, flush, write_xfer;
  logic [2:0] occupancy;

  assign inst_valid = (count_q != 2'd0);
  assign inst_pc    = pc0_q;
  assign inst_data  = inst0_q;
  assign pop        = inst_valid && inst_ready;
  assign occupancy  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

  assign load_ready    = (state_q == S_LOAD);
  assign write_xfer    = load_ready && load_valid;
  assign mem_rw_enable = !write_xfer;
  assign mem_data_in   = write_xfer ? load_data : 16'h0000;
  assign mem_address   = write_xfer ? load_addr :
                         (state_q == S_IDLE) ? 8'h00 : fetch_pc_q;

  // Entry 0 is always the head, so its contents stay put while the buffer is empty.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    pc0_d         = pc0_q;
    pc1_d         = pc1_q;
    inst0_d       = inst0_q;
    inst1_d       = inst1_q;
    issue         = 1'b0;
    flush         = 1'b0;
    push          = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = load_mode ? S_LOAD : S_FETCH;
      S_FETCH: begin
        if (load_mode) begin
          state_d = S_LOAD;
          flush   = 1'b1;
        end else if (redirect_valid) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc;
        end else begin
          push  = inflight_q;
          issue = (occupancy <= 3'd1);
        end
      end
      S_LOAD: begin
        if (!load_mode) begin
          state_d    = S_FETCH;
          fetch_pc_d = START_PC;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      fetch_pc_d    = fetch_pc_q + 8'd1;
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_pc_q;
    end

    if (flush) begin
      count_d = 2'd0;
    end else begin
      if (pop && (count_q == 2'd2)) begin
        pc0_d   = pc1_q;
        inst0_d = inst1_q;
      end
      if (push) begin
        if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
          pc0_d   = inflight_pc_q;
          inst0_d = mem_data_out;
        end else begin
          pc1_d   = inflight_pc_q;
          inst1_d = mem_data_out;
        end
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      fetch_pc_q    <= START_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 8'h00;
      count_q       <= 2'd0;
      pc0_q         <= 8'h00;
      pc1_q         <= 8'h00;
      inst0_q       <= 16'h0000;
      inst1_q       <= 16'h0000;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      pc0_q         <= pc0_d;
      pc1_q         <= pc1_d;
      inst0_q       <= inst0_d;
      inst1_q       <= inst1_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: one instance at START_PC 0x00 with a load/run
// scenario, one at START_PC 0xFE for PC wrap-around.
module tb_inst_fetch_unit;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] data;
  } exp_t;

  logic clk;
  int   checks;
  int   errors;
  int   rwLowA;

  logic        rstA_n, loadModeA, loadValidA, loadReadyA, redirectValidA;
  logic [7:0]  loadAddrA, redirectPcA, instPcA, memAddrA;
  logic [15:0] loadDataA, instDataA, memDinA, memDoutA;
  logic        instValidA, instReadyA, memRwA;
  logic [15:0] memA [256];
  exp_t        qA [$];

  logic        rstB_n, loadReadyB, instValidB, instReadyB, memRwB;
  logic [7:0]  instPcB, memAddrB;
  logic [15:0] instDataB, memDinB, memDoutB;
  logic [15:0] memB [256];
  exp_t        qB [$];

  inst_fetch_unit #(.START_PC(8'h00)) dutA (
    .clk(clk), .rst_n(rstA_n), .load_mode(loadModeA), .load_valid(loadValidA),
    .load_ready(loadReadyA), .load_addr(loadAddrA), .load_data(loadDataA),
    .redirect_valid(redirectValidA), .redirect_pc(redirectPcA),
    .inst_valid(instValidA), .inst_ready(instReadyA), .inst_data(instDataA),
    .inst_pc(instPcA), .mem_rw_enable(memRwA), .mem_address(memAddrA),
    .mem_data_in(memDinA), .mem_data_out(memDoutA)
  );

  inst_fetch_unit #(.START_PC(8'hFE)) dutB (
    .clk(clk), .rst_n(rstB_n), .load_mode(1'b0), .load_valid(1'b0),
    .load_ready(loadReadyB), .load_addr(8'h00), .load_data(16'h0000),
    .redirect_valid(1'b0), .redirect_pc(8'h00),
    .inst_valid(instValidB), .inst_ready(instReadyB), .inst_data(instDataB),
    .inst_pc(instPcB), .mem_rw_enable(memRwB), .mem_address(memAddrB),
    .mem_data_in(memDinB), .mem_data_out(memDoutB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous 256x16 memories with registered read data, preloaded with a tagged pattern.
  initial begin
    memDoutA = 16'h0000;
    for (int i = 0; i < 256; i++) memA[i] = 16'hA000 + 16'(i);
    forever begin
      @(posedge clk);
      if (!memRwA) memA[memAddrA] <= memDinA;
      else memDoutA <= memA[memAddrA];
    end
  end

  initial begin
    memDoutB = 16'h0000;
    for (int i = 0; i < 256; i++) memB[i] = 16'hB000 + 16'(i);
    forever begin
      @(posedge clk);
      if (!memRwB) memB[memAddrB] <= memDinB;
      else memDoutB <= memB[memAddrB];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic lm, input logic lv, input logic [7:0] la,
                               input logic [15:0] ld, input logic rv,
                               input logic [7:0] rp, input logic rdy);
    loadModeA      = lm;
    loadValidA     = lv;
    loadAddrA      = la;
    loadDataA      = ld;
    redirectValidA = rv;
    redirectPcA    = rp;
    instReadyA     = rdy;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rstA_n && !memRwA) rwLowA++;
  end

  // Monitors: every accepted instruction must match the head of its expectation queue.
  always @(negedge clk) begin
    exp_t e;
    if (rstA_n && instValidA && instReadyA) begin
      if (qA.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL A unexpected: got pc %0h data %0h, expected none", instPcA, instDataA);
      end else begin
        e = qA.pop_front();
        checkOutput("A inst_pc", 32'(instPcA), 32'(e.pc));
        checkOutput("A inst_data", 32'(instDataA), 32'(e.data));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rstB_n && instValidB && instReadyB) begin
      if (qB.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL B unexpected: got pc %0h data %0h, expected none", instPcB, instDataB);
      end else begin
        e = qB.pop_front();
        checkOutput("B inst_pc", 32'(instPcB), 32'(e.pc));
        checkOutput("B inst_data", 32'(instDataB), 32'(e.data));
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rwLowA = 0;
    rstA_n = 1'b1;
    rstB_n = 1'b1;
    instReadyB = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0);
    #1;
    rstA_n = 1'b0;
    rstB_n = 1'b0;
    #1;
    checkOutput("reset rw", 32'(memRwA), 32'd1);
    checkOutput("reset valid", 32'(instValidA), 32'd0);
    checkOutput("reset load_ready", 32'(loadReadyA), 32'd0);
    checkOutput("reset addr", 32'(memAddrA), 32'h00);
    checkOutput("reset inst_pc", 32'(instPcA), 32'h00);
    nextCycle();
    nextCycle();
    rstA_n = 1'b1;
    #3;
    checkOutput("idle load_ready", 32'(loadReadyA), 32'd0);

    nextCycle();
    applyStimulus(1'b1, 1'b1, 8'h00, 16'h1111, 1'b0, 8'h00, 1'b0);
    #3;
    checkOutput("load1 load_ready", 32'(loadReadyA), 32'd1);
    checkOutput("load1 rw", 32'(memRwA), 32'd0);
    checkOutput("load1 addr", 32'(memAddrA), 32'h00);
    checkOutput("load1 din", 32'(memDinA), 32'h1111);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 8'h01, 16'h2222, 1'b0, 8'h00, 1'b0);
    #3;
    checkOutput("load2 rw", 32'(memRwA), 32'd0);
    checkOutput("load2 addr", 32'(memAddrA), 32'h01);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 8'h02, 16'h3333, 1'b0, 8'h00, 1'b0);
    #3;
    checkOutput("load3 rw", 32'(memRwA), 32'd0);
    checkOutput("load3 din", 32'(memDinA), 32'h3333);

    nextCycle();
    applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b1);
    qA.push_back('{8'h00, 16'h1111});
    qA.push_back('{8'h01, 16'h2222});
    qA.push_back('{8'h02, 16'h3333});
    for (int i = 3; i <= 6; i++) qA.push_back('{8'(i), 16'hA000 + 16'(i)});
    #3;
    checkOutput("load exit rw", 32'(memRwA), 32'd1);
    checkOutput("write cycle count", 32'(rwLowA), 32'd3);

    nextCycle();
    #3;
    checkOutput("first fetch valid", 32'(instValidA), 32'd0);
    checkOutput("first fetch addr", 32'(memAddrA), 32'h00);
    nextCycle();
    #3;
    checkOutput("latency valid low", 32'(instValidA), 32'd0);
    nextCycle();
    #3;
    checkOutput("latency valid high", 32'(instValidA), 32'd1);
    checkOutput("latency pc", 32'(instPcA), 32'h00);
    nextCycle();

    nextCycle();
    applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0);
    #3;
    checkOutput("stall addr", 32'(memAddrA), 32'h04);
    nextCycle();
    nextCycle();
    #3;
    checkOutput("full addr", 32'(memAddrA), 32'h04);
    nextCycle();
    nextCycle();
    #3;
    checkOutput("full end addr", 32'(memAddrA), 32'h04);
    checkOutput("full head pc", 32'(instPcA), 32'h02);
    checkOutput("full valid", 32'(instValidA), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b1);
    nextCycle();
    nextCycle();
    nextCycle();

    nextCycle();
    applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h40, 1'b1);
    qA.push_back('{8'h40, 16'hA040});
    qA.push_back('{8'h41, 16'hA041});
    nextCycle();
    applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b1);
    #3;
    checkOutput("redirect flush valid", 32'(instValidA), 32'd0);
    checkOutput("redirect addr", 32'(memAddrA), 32'h40);
    nextCycle();
    #3;
    checkOutput("killed read absent", 32'(instValidA), 32'd0);
    nextCycle();
    #3;
    checkOutput("redirect target valid", 32'(instValidA), 32'd1);
    checkOutput("redirect target pc", 32'(instPcA), 32'h40);
    nextCycle();

    nextCycle();
    applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0);
    #3;
    checkOutput("pre-switch valid", 32'(instValidA), 32'd1);
    nextCycle();
    #3;
    checkOutput("switch valid drop", 32'(instValidA), 32'd0);
    checkOutput("switch load_ready", 32'(loadReadyA), 32'd1);
    checkOutput("scoreboard drained", 32'(qA.size()), 32'd0);

    nextCycle();
    applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b1);
    qA.push_back('{8'h00, 16'h1111});
    qA.push_back('{8'h01, 16'h2222});
    qA.push_back('{8'h02, 16'h3333});
    nextCycle();
    nextCycle();
    nextCycle();
    #3;
    checkOutput("restart pc", 32'(instPcA), 32'h00);
    nextCycle();
    nextCycle();
    applyStimulus(1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b1);

    nextCycle();
    applyStimulus(1'b1, 1'b1, 8'h10, 16'h5555, 1'b0, 8'h00, 1'b1);
    #3;
    checkOutput("burst rw", 32'(memRwA), 32'd0);
    checkOutput("burst valid", 32'(instValidA), 32'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 8'h11, 16'h6666, 1'b0, 8'h00, 1'b1);
    #2;
    rstA_n = 1'b0;
    #1;
    checkOutput("async rw", 32'(memRwA), 32'd1);
    checkOutput("async valid", 32'(instValidA), 32'd0);
    checkOutput("async load_ready", 32'(loadReadyA), 32'd0);
    checkOutput("async addr", 32'(memAddrA), 32'h00);
    nextCycle();
    nextCycle();
    checkOutput("total write cycles", 32'(rwLowA), 32'd4);
    checkOutput("mem[10] written", 32'(memA[8'h10]), 32'h5555);
    checkOutput("mem[11] untouched", 32'(memA[8'h11]), 32'hA011);
    checkOutput("A scoreboard empty", 32'(qA.size()), 32'd0);

    qB.push_back('{8'hFE, 16'hB0FE});
    qB.push_back('{8'hFF, 16'hB0FF});
    qB.push_back('{8'h00, 16'hB000});
    qB.push_back('{8'h01, 16'hB001});
    nextCycle();
    rstB_n = 1'b1;
    #3;
    checkOutput("B idle valid", 32'(instValidB), 32'd0);
    nextCycle();
    nextCycle();
    #3;
    checkOutput("B latency valid low", 32'(instValidB), 32'd0);
    nextCycle();
    instReadyB = 1'b1;
    #3;
    checkOutput("B first valid", 32'(instValidB), 32'd1);
    nextCycle();
    nextCycle();
    nextCycle();
    nextCycle();
    instReadyB = 1'b0;
    #3;
    checkOutput("B scoreboard empty", 32'(qB.size()), 32'd0);
    nextCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
